// File: rtl/proc_pkg.sv
// Shared definitions for the processor front end: instruction word layout,
// special opcodes and the fetch FSM state encoding.
//   PC_WIDTH     instruction address width (PC wraps modulo 2**PC_WIDTH)
//   INSTR_WIDTH  instruction word width: [15:10] opcode, [9:0] operand
//   OPC_WIDTH    opcode width, matches the sequencer IR input
package proc_pkg;

    localparam int PC_WIDTH    = 8;
    localparam int INSTR_WIDTH = 16;
    localparam int OPC_WIDTH   = 6;
    localparam int OPND_WIDTH  = 10;

    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 10;
    localparam int OPND_MSB = 9;
    localparam int OPND_LSB = 0;

    localparam logic [OPC_WIDTH-1:0] OPC_NOP  = 6'd0;
    localparam logic [OPC_WIDTH-1:0] OPC_HALT = 6'd63;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_EXEC,
        ST_HALT
    } fetch_state_t;

    function automatic logic [OPC_WIDTH-1:0] opc_of(input logic [INSTR_WIDTH-1:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [OPND_WIDTH-1:0] opnd_of(input logic [INSTR_WIDTH-1:0] word);
        return word[OPND_MSB:OPND_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register.
//   clk       clock
//   rst       synchronous active-high clear
//   inc       advance by one, wrapping modulo 2**WIDTH
//   load      load load_val (wins over inc)
//   load_val  jump target
//   pc        current program counter
module pc_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] pc
);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + 1'b1;   // natural wrap at 2**WIDTH
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit feeding the microcode sequencer. Reads instruction
// RAM at pc, presents the opcode until the sequencer reports completion, and
// forces opcode 0 between instructions so the sequencer step counter rewinds.
// NOP words are skipped, opcode 63 halts, and the datapath may jump in EXEC.
//   clk, rst            clock, synchronous active-high reset
//   start               begin fetching (honoured in IDLE only)
//   iram_addr/rd_en     RAM address (= pc) and one-cycle read request
//   iram_data/valid     RAM read data and its valid strobe
//   instr_done          sequencer completion pulse (honoured in EXEC only)
//   pc_load/pc_load_val datapath jump request and target (EXEC only)
//   ir_opcode           opcode to sequencer, 0 outside EXEC
//   ir_operand          operand field of the latched instruction
//   pc, busy, halted    program counter and status flags
module instr_fetch_unit
    import proc_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [PC_WIDTH-1:0]    iram_addr,
    output logic                   iram_rd_en,
    input  logic [INSTR_WIDTH-1:0] iram_data,
    input  logic                   iram_valid,
    input  logic                   instr_done,
    input  logic                   pc_load,
    input  logic [PC_WIDTH-1:0]    pc_load_val,
    output logic [OPC_WIDTH-1:0]   ir_opcode,
    output logic [OPND_WIDTH-1:0]  ir_operand,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   busy,
    output logic                   halted
);

    fetch_state_t           state;
    logic                   pc_inc;
    logic                   pc_jump;
    logic [OPC_WIDTH-1:0]   fetched_opc;

    assign fetched_opc = opc_of(iram_data);

    // Returned data is only meaningful while a read is outstanding; a late
    // strobe after a reset or in any other state must not move the PC.
    assign pc_inc  = (state == ST_WAIT) && iram_valid;
    assign pc_jump = (state == ST_EXEC) && pc_load;

    pc_reg #(.WIDTH(PC_WIDTH)) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .inc      (pc_inc),
        .load     (pc_jump),
        .load_val (pc_load_val),
        .pc       (pc)
    );

    assign iram_addr = pc;

    // The latched instruction is split: the operand half is held in
    // ir_operand, the opcode half only reaches the sequencer in EXEC so that
    // it reads as 0 through every REQ/WAIT gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            iram_rd_en <= 1'b0;
            ir_opcode  <= '0;
            ir_operand <= '0;
            busy       <= 1'b0;
            halted     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_REQ;
                        iram_rd_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                ST_REQ: begin
                    iram_rd_en <= 1'b0;
                    state      <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (iram_valid) begin
                        ir_operand <= opnd_of(iram_data);
                        if (fetched_opc == OPC_NOP) begin
                            state      <= ST_REQ;
                            iram_rd_en <= 1'b1;
                        end else if (fetched_opc == OPC_HALT) begin
                            state  <= ST_HALT;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end else begin
                            state     <= ST_EXEC;
                            ir_opcode <= fetched_opc;
                        end
                    end
                end

                ST_EXEC: begin
                    // A jump in the same cycle is applied by pc_reg, so the
                    // REQ that follows already addresses the new target.
                    if (instr_done) begin
                        ir_opcode  <= '0;
                        state      <= ST_REQ;
                        iram_rd_en <= 1'b1;
                    end
                end

                ST_HALT: begin
                    // Only reset leaves HALT.
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
